sd_cmd_engine: RTL and testbench
================================

Name: sd_cmd_engine

Overview:
Hardware SD-bus CMD-line engine: the counterpart to the bit-banged CMD PIO, used when software must not toggle the line bit by bit. It serialises a 48-bit host command (start bit, index, argument, CRC7, end bit) onto the open-drain-style CMD line and captures the card's 48-bit response (R1/R3/R6/R7). It sits on the Qsys Avalon-MM bus beside the SD DAT PIOs, owns the SD clock output, and interrupts the CPU on completion.

Parameters:
CLK_DIV, 2, sd_clk half-period in clk cycles (sd_clk = clk/(2*CLK_DIV)); legal range 1..255
RESP_TIMEOUT, 64, sd_clk rising edges to wait for a response start bit (Ncr)

Ports:
clk  in  1  system clock
reset_n  in  1  async active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
sd_clk  out  1  SD clock
sd_cmd  inout  1  SD CMD line; driven only while transmitting, else Z (external pull-up)
irq  out  1  level interrupt = done flag

Behaviour:
- Reset applies on reset_n low, asynchronous; clock clk. Reset values: readdata=0, sd_clk=0, sd_cmd=Z, irq=0, all flags/registers 0, FSM=IDLE.
- Register map:
  - addr0 ARG: RW 32-bit command argument.
  - addr1 write CMD: [5:0]=index, [6]=resp_expected, [7]=crc_check. Starts a transaction if busy=0; ignored if busy=1.
  - addr1 read STATUS: [0] busy, [1] done, [2] timeout, [3] crc_err, [4] end_err, [5] tx_bit_err (response transmission bit != 0).
  - addr2 read RESP_ARG: response bits [39:8].
  - addr3 read RESP_HDR: [13:8] response index, [6:0] received CRC7.
  - addr3 write (any data): clears done and all error flags. Set in the same clk as a clear: set wins.
- readdata is updated every clk from the address mux; read latency 1 clk. Unmapped bits read 0.
- sd_clk generator:
  - Free-running divider toggles sd_clk every CLK_DIV clks.
  - fall_tick = clk where sd_clk goes 1->0; host updates sd_cmd on fall_tick.
  - rise_tick = clk where sd_clk goes 0->1; receiver samples sd_cmd on rise_tick.
- On CMD accept:
  - Latch index, flags and ARG into a 48-bit shift register; busy=1 next clk.
  - Clear done and errors.
  - FSM=TX.
- Frame format, MSB first: 0, 1, index[5:0], arg[31:0], crc7[6:0], 1.
  - CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits serially during shifting.
- FSM:
  - IDLE: sd_cmd=Z.
  - TX:
    - First bit driven at the first fall_tick after accept. Drive one bit per fall_tick, 48 bits.
    - At the 49th fall_tick release sd_cmd (Z).
    - If resp_expected=0: done=1, busy=0, go to IDLE.
    - Else go to WAIT.
  - WAIT:
    - Count rise_ticks. sd_cmd=0 sampled on a rise_tick -> RX (start bit counted).
    - If the counter reaches RESP_TIMEOUT with no start bit: timeout=1, done=1, go to IDLE.
  - RX:
    - Sample 47 further bits on rise_ticks.
    - Receiver CRC7 runs over response bits 47..8.
    - At completion:
      - tx_bit_err if bit46 != 0.
      - end_err if bit0 != 1.
      - crc_err if crc_check=1 and the received CRC differs from the computed CRC.
    - Load RESP_ARG/RESP_HDR, done=1, busy=0, go to IDLE.
- irq tracks done combinationally from the registered flag.
- ARG writes while busy update the ARG register only; the in-flight frame is unaffected.
- Reset mid-transaction releases sd_cmd immediately (async), aborts, and leaves no flags set.

Test Plan:
- CMD0: ARG=0, CMD=0x00 -> sd_cmd carries 0x400000000095 MSB-first over 48 sd_clk, then Z. STATUS reads 0x2, irq=1, no RX entered.
- CMD8 R7: ARG=0x1AA, CMD=0xC8 (resp+crc). Card model replies after 5 sd_clk with index 8, arg 0x000001AA, correct CRC -> RESP_ARG=0x000001AA, RESP_HDR[13:8]=8, STATUS=0x2.
- Same as CMD8 R7 with one CRC bit flipped -> STATUS=0xA. Write addr3 -> STATUS=0x0, irq=0.
- CMD41 R3 with crc_check=0: CMD=0x69, response index field 0x3F, arg 0x80FF8000, CRC field 0x7F, end 1 -> RESP_ARG=0x80FF8000, STATUS=0x2.
- Timeout: CMD=0x51, no card response -> after exactly 64 rise_ticks in WAIT, STATUS=0x6, sd_cmd stays Z.
- Busy ignore and reset: write CMD=0x11 during TX -> frame unchanged. Assert reset_n at bit 20 -> sd_cmd=Z same clk, STATUS=0, sd_clk=0.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD-bus CMD-line engine: serialises 48-bit commands, captures 48-bit responses
module sd_cmd_engine #(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    inout  wire         sd_cmd,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_WAIT, S_RX} state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        sd_clk_q, sd_clk_d;
    logic [31:0] arg_q, arg_d;
    logic [47:0] shift_q, shift_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic [6:0]  crc_q, crc_d;
    logic        cmd_oe_q, cmd_oe_d;
    logic        cmd_out_q, cmd_out_d;
    logic        resp_exp_q, resp_exp_d;
    logic        crc_chk_q, crc_chk_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [47:0] rx_shift_q, rx_shift_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [6:0]  rx_crc_q, rx_crc_d;
    logic [31:0] resp_arg_q, resp_arg_d;
    logic [5:0]  resp_idx_q, resp_idx_d;
    logic [6:0]  resp_crc_q, resp_crc_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        crc_err_q, crc_err_d;
    logic        end_err_q, end_err_d;
    logic        tx_bit_err_q, tx_bit_err_d;
    logic [31:0] readdata_q, readdata_d;

    logic tick, fall_tick, rise_tick, wr, busy;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ({7{b ^ c[6]}} & 7'h09);
    endfunction

    assign sd_clk   = sd_clk_q;
    assign sd_cmd   = cmd_oe_q ? cmd_out_q : 1'bz;
    assign irq      = done_q;
    assign readdata = readdata_q;

    always_comb begin
        tick       = (div_cnt_q == DIV_LAST);
        fall_tick  = tick & sd_clk_q;
        rise_tick  = tick & ~sd_clk_q;
        div_cnt_d  = tick ? 8'd0 : div_cnt_q + 8'd1;
        sd_clk_d   = tick ? ~sd_clk_q : sd_clk_q;
        wr         = chipselect & ~write_n;
        busy       = (state_q != S_IDLE);

        state_d      = state_q;
        arg_d        = arg_q;
        shift_d      = shift_q;
        tx_cnt_d     = tx_cnt_q;
        crc_d        = crc_q;
        cmd_oe_d     = cmd_oe_q;
        cmd_out_d    = cmd_out_q;
        resp_exp_d   = resp_exp_q;
        crc_chk_d    = crc_chk_q;
        to_cnt_d     = to_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_cnt_d     = rx_cnt_q;
        rx_crc_d     = rx_crc_q;
        resp_arg_d   = resp_arg_q;
        resp_idx_d   = resp_idx_q;
        resp_crc_d   = resp_crc_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        crc_err_d    = crc_err_q;
        end_err_d    = end_err_q;
        tx_bit_err_d = tx_bit_err_q;

        if (wr && address == 2'd0) begin
            arg_d = writedata;
        end

        // Clears come first so that any flag set later in this cycle wins.
        if ((wr && address == 2'd3) || (wr && address == 2'd1 && !busy)) begin
            done_d       = 1'b0;
            timeout_d    = 1'b0;
            crc_err_d    = 1'b0;
            end_err_d    = 1'b0;
            tx_bit_err_d = 1'b0;
        end

        if (wr && address == 2'd1 && !busy) begin
            shift_d    = {2'b01, writedata[5:0], arg_q, 7'd0, 1'b1};
            tx_cnt_d   = 6'd0;
            crc_d      = 7'd0;
            resp_exp_d = writedata[6];
            crc_chk_d  = writedata[7];
            state_d    = S_TX;
        end

        case (state_q)
            S_TX: begin
                if (fall_tick) begin
                    if (tx_cnt_q == 6'd48) begin
                        cmd_oe_d = 1'b0;
                        if (resp_exp_q) begin
                            to_cnt_d = 16'd0;
                            state_d  = S_WAIT;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        // Bits 40..46 are driven from the running CRC rather than the shift register.
                        cmd_oe_d  = 1'b1;
                        cmd_out_d = (tx_cnt_q >= 6'd40 && tx_cnt_q < 6'd47) ? crc_q[6] : shift_q[47];
                        shift_d   = {shift_q[46:0], 1'b0};
                        tx_cnt_d  = tx_cnt_q + 6'd1;
                        crc_d     = (tx_cnt_q < 6'd40) ? crc7_step(crc_q, shift_q[47])
                                                       : {crc_q[5:0], 1'b0};
                    end
                end
            end
            S_WAIT: begin
                if (rise_tick) begin
                    if (sd_cmd == 1'b0) begin
                        rx_cnt_d   = 6'd1;
                        rx_shift_d = 48'd0;
                        rx_crc_d   = 7'd0;
                        state_d    = S_RX;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
            end
            S_RX: begin
                if (rise_tick) begin
                    rx_shift_d = {rx_shift_q[46:0], sd_cmd};
                    rx_cnt_d   = rx_cnt_q + 6'd1;
                    if (rx_cnt_q < 6'd40) begin
                        rx_crc_d = crc7_step(rx_crc_q, sd_cmd);
                    end
                    if (rx_cnt_q == 6'd47) begin
                        if (rx_shift_d[46]) tx_bit_err_d = 1'b1;
                        if (!rx_shift_d[0]) end_err_d = 1'b1;
                        if (crc_chk_q && (rx_shift_d[7:1] != rx_crc_q)) crc_err_d = 1'b1;
                        resp_arg_d = rx_shift_d[39:8];
                        resp_idx_d = rx_shift_d[45:40];
                        resp_crc_d = rx_shift_d[7:1];
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                cmd_oe_d = 1'b0;
            end
        endcase

        case (address)
            2'd0:    readdata_d = arg_q;
            2'd1:    readdata_d = {26'd0, tx_bit_err_q, end_err_q, crc_err_q, timeout_q, done_q, busy};
            2'd2:    readdata_d = resp_arg_q;
            default: readdata_d = {18'd0, resp_idx_q, 1'b0, resp_crc_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= 8'd0;
            sd_clk_q     <= 1'b0;
            arg_q        <= 32'd0;
            shift_q      <= 48'd0;
            tx_cnt_q     <= 6'd0;
            crc_q        <= 7'd0;
            cmd_oe_q     <= 1'b0;
            cmd_out_q    <= 1'b0;
            resp_exp_q   <= 1'b0;
            crc_chk_q    <= 1'b0;
            to_cnt_q     <= 16'd0;
            rx_shift_q   <= 48'd0;
            rx_cnt_q     <= 6'd0;
            rx_crc_q     <= 7'd0;
            resp_arg_q   <= 32'd0;
            resp_idx_q   <= 6'd0;
            resp_crc_q   <= 7'd0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            end_err_q    <= 1'b0;
            tx_bit_err_q <= 1'b0;
            readdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            sd_clk_q     <= sd_clk_d;
            arg_q        <= arg_d;
            shift_q      <= shift_d;
            tx_cnt_q     <= tx_cnt_d;
            crc_q        <= crc_d;
            cmd_oe_q     <= cmd_oe_d;
            cmd_out_q    <= cmd_out_d;
            resp_exp_q   <= resp_exp_d;
            crc_chk_q    <= crc_chk_d;
            to_cnt_q     <= to_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_crc_q     <= rx_crc_d;
            resp_arg_q   <= resp_arg_d;
            resp_idx_q   <= resp_idx_d;
            resp_crc_q   <= resp_crc_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            crc_err_q    <= crc_err_d;
            end_err_q    <= end_err_d;
            tx_bit_err_q <= tx_bit_err_d;
            readdata_q   <= readdata_d;
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - directed self-checking bench for sd_cmd_engine
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        sd_clk;
    wire         sd_cmd;
    logic        irq;

    logic card_oe = 1'b0;
    logic card_bit = 1'b1;
    logic sd_clk_d = 1'b0;
    int   total = 0;
    int   bad = 0;

    assign sd_cmd = card_oe ? card_bit : 1'bz;
    pullup (sd_cmd);

    sd_cmd_engine #(.CLK_DIV(2), .RESP_TIMEOUT(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_clk     (sd_clk),
        .sd_cmd     (sd_cmd),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) sd_clk_d <= sd_clk;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic sd_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sd_clk && !sd_clk_d) begin ok = 1'b1; break; end
        end
    endtask

    task automatic sd_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!sd_clk && sd_clk_d) begin ok = 1'b1; break; end
        end
    endtask

    task automatic get_frame(output logic [47:0] f, output bit ok);
        bit e;
        ok = 1'b0;
        f = 48'd0;
        for (int i = 0; i < 32; i++) begin
            sd_rise(e);
            if (!e) return;
            if (sd_cmd === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        for (int i = 0; i < 47; i++) begin
            sd_rise(e);
            if (!e) begin ok = 1'b0; return; end
            f = {f[46:0], sd_cmd};
        end
    endtask

    task automatic card_reply(input logic [47:0] r, output bit ok);
        bit e;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sd_fall(e);
            if (!e) ok = 1'b0;
        end
        for (int i = 47; i >= 0; i--) begin
            sd_fall(e);
            if (!e) ok = 1'b0;
            card_oe = 1'b1;
            card_bit = r[i];
        end
        sd_fall(e);
        card_oe = 1'b0;
        card_bit = 1'b1;
    endtask

    task automatic wait_irq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (irq === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata got=%h want=0", readdata); end
        total++; if (sd_clk !== 1'b0) begin bad++; $display("FAIL reset_sd_clk got=%b want=0", sd_clk); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        total++; if (sd_cmd !== 1'b1) begin bad++; $display("FAIL reset_sd_cmd got=%b want=released", sd_cmd); end
        reset_n = 1'b1;
        rd_reg(2'd1, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_status got=%h want=0", d); end
    endtask

    task automatic test_cmd0;
        logic [47:0] f;
        logic [31:0] d;
        bit ok;
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'h00);
        get_frame(f, ok);
        total++; if (!ok) begin bad++; $display("FAIL cmd0_start got=none want=frame"); end
        total++; if (f !== 48'h400000000095) begin bad++; $display("FAIL cmd0_frame got=%h want=400000000095", f); end
        wait_irq(ok);
        total++; if (!ok) begin bad++; $display("FAIL cmd0_done got=timeout want=irq"); end
        rd_reg(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL cmd0_status got=%h want=2", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL cmd0_irq got=%b want=1", irq); end
        rd_reg(2'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL cmd0_no_rx got=%h want=0", d); end
    endtask

    task automatic test_cmd8(input bit flip);
        logic [47:0] f, r;
        logic [31:0] d;
        logic [6:0]  c;
        bit ok;
        c = crc7({2'b00, 6'd8, 32'h000001AA});
        r = {2'b00, 6'd8, 32'h000001AA, c, 1'b1};
        if (flip) r = r ^ 48'h2;
        wr_reg(2'd0, 32'h1AA);
        wr_reg(2'd1, 32'hC8);
        get_frame(f, ok);
        total++; if (f !== 48'h48000001AA87) begin bad++; $display("FAIL cmd8_frame got=%h want=48000001aa87", f); end
        card_reply(r, ok);
        wait_irq(ok);
        total++; if (!ok) begin bad++; $display("FAIL cmd8_done got=timeout want=irq"); end
        if (!flip) begin
            rd_reg(2'd2, d);
            total++; if (d !== 32'h000001AA) begin bad++; $display("FAIL cmd8_resp_arg got=%h want=000001aa", d); end
            rd_reg(2'd3, d);
            total++; if (d[13:8] !== 6'd8) begin bad++; $display("FAIL cmd8_resp_idx got=%h want=08", d[13:8]); end
            total++; if (d[6:0] !== c) begin bad++; $display("FAIL cmd8_resp_crc got=%h want=%h", d[6:0], c); end
            rd_reg(2'd1, d);
            total++; if (d !== 32'h2) begin bad++; $display("FAIL cmd8_status got=%h want=2", d); end
        end else begin
            rd_reg(2'd1, d);
            total++; if (d !== 32'hA) begin bad++; $display("FAIL crcerr_status got=%h want=a", d); end
            total++; if (irq !== 1'b1) begin bad++; $display("FAIL crcerr_irq got=%b want=1", irq); end
            wr_reg(2'd3, 32'd0);
            rd_reg(2'd1, d);
            total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_status got=%h want=0", d); end
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b want=0", irq); end
        end
    endtask

    task automatic test_cmd41;
        logic [47:0] f;
        logic [31:0] d;
        bit ok;
        wr_reg(2'd0, 32'h40FF8000);
        wr_reg(2'd1, 32'h69);
        get_frame(f, ok);
        total++; if (f[45:40] !== 6'd41) begin bad++; $display("FAIL cmd41_index got=%h want=29", f[45:40]); end
        card_reply({2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}, ok);
        wait_irq(ok);
        rd_reg(2'd2, d);
        total++; if (d !== 32'h80FF8000) begin bad++; $display("FAIL cmd41_resp_arg got=%h want=80ff8000", d); end
        rd_reg(2'd3, d);
        total++; if (d !== 32'h3F7F) begin bad++; $display("FAIL cmd41_resp_hdr got=%h want=3f7f", d); end
        rd_reg(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL cmd41_status got=%h want=2", d); end
    endtask

    task automatic test_timeout;
        logic [47:0] f;
        logic [31:0] d;
        bit ok, e;
        wr_reg(2'd1, 32'h51);
        get_frame(f, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_frame got=none want=frame"); end
        for (int i = 1; i <= 64; i++) begin
            sd_rise(e);
            if (!e) begin
                total++; bad++; $display("FAIL to_sd_clk got=stalled want=running");
                break;
            end
            if (i == 63) begin
                total++; if (irq !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", irq); end
                total++; if (sd_cmd !== 1'b1) begin bad++; $display("FAIL to_line got=%b want=released", sd_cmd); end
            end
            if (i == 64) begin
                total++; if (irq !== 1'b1) begin bad++; $display("FAIL to_at_64 got=%b want=1", irq); end
            end
        end
        rd_reg(2'd1, d);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL to_status got=%h want=6", d); end
    endtask

    task automatic test_busy_reset;
        logic [47:0] f;
        logic [31:0] d;
        bit ok, e;
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'h00);
        fork
            get_frame(f, ok);
            begin
                repeat (60) @(negedge clk);
                wr_reg(2'd1, 32'h11);
                wr_reg(2'd0, 32'hFFFFFFFF);
            end
        join
        total++; if (f !== 48'h400000000095) begin bad++; $display("FAIL busy_frame got=%h want=400000000095", f); end
        wait_irq(ok);
        rd_reg(2'd0, d);
        total++; if (d !== 32'hFFFFFFFF) begin bad++; $display("FAIL busy_arg got=%h want=ffffffff", d); end
        rd_reg(2'd1, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL busy_status got=%h want=2", d); end

        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'h00);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sd_rise(e);
            if (sd_cmd === 1'b0) begin ok = 1'b1; break; end
        end
        for (int i = 0; i < 20; i++) sd_rise(e);
        total++; if (!ok || sd_cmd !== 1'b0) begin bad++; $display("FAIL rst_pre_drive got=%b want=0", sd_cmd); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (sd_cmd !== 1'b1) begin bad++; $display("FAIL rst_release got=%b want=released", sd_cmd); end
        total++; if (sd_clk !== 1'b0) begin bad++; $display("FAIL rst_sd_clk got=%b want=0", sd_clk); end
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(2'd1, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_status got=%h want=0", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8(1'b0);
        test_cmd8(1'b1);
        test_cmd41();
        test_timeout();
        test_busy_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
